// File: rtl/voxel_memory_grid.sv
// voxel_memory_grid: dual-port coordinate-addressed voxel store with byte-masked
// writes, configurable read-during-write behaviour and a bulk-clear sequencer.
module voxel_memory_grid #(
  parameter int unsigned       X_BITS      = 6,
  parameter int unsigned       Y_BITS      = 6,
  parameter int unsigned       Z_BITS      = 6,
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
  parameter bit                WRITE_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [X_BITS-1:0]        rd_x,
  input  logic [Y_BITS-1:0]        rd_y,
  input  logic [Z_BITS-1:0]        rd_z,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     wr_en,
  input  logic [X_BITS-1:0]        wr_x,
  input  logic [Y_BITS-1:0]        wr_y,
  input  logic [Z_BITS-1:0]        wr_z,
  input  logic [(DATA_W/8)-1:0]    wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_drop,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     clear_done
);

  localparam int unsigned A_W   = X_BITS + Y_BITS + Z_BITS;
  localparam int unsigned DEPTH = 2 ** A_W;
  localparam int unsigned BE_W  = DATA_W / 8;

  // Counter is one bit wider than the address so the last-address match is unambiguous.
  localparam logic [A_W:0] CNT_LAST = {1'b0, {A_W{1'b1}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]        r_state;
  logic [A_W:0]      r_cnt;
  logic              r_clear_busy;
  logic              r_clear_done;
  logic              r_wr_drop;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic [1:0]        w_state_nxt;
  logic [A_W:0]      w_cnt_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  logic              w_we;
  logic [A_W-1:0]    w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_wbe;
  logic [DATA_W-1:0] w_wmask;
  logic [A_W-1:0]    w_raddr;
  logic [DATA_W-1:0] w_rd_old;
  logic [DATA_W-1:0] w_rd_next;

  assign w_raddr = {rd_x, rd_y, rd_z};

  // Clear FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_clear_busy <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_clear_busy <= w_busy_nxt;
      r_clear_done <= w_done_nxt;
    end
  end

  // Clear FSM next state: one full sweep, then a single done cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_CLEAR: begin
        w_cnt_nxt  = r_cnt + (A_W+1)'(1);
        w_busy_nxt = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Write-port arbitration: the sweep owns the port while clearing.
  always_comb begin
    w_we    = wr_en;
    w_waddr = {wr_x, wr_y, wr_z};
    w_wdata = wr_data;
    w_wbe   = wr_be;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_cnt[A_W-1:0];
      w_wdata = CLEAR_VALUE;
      w_wbe   = '1;
    end
  end

  // Expand byte enables into a bit mask for the bypass merge.
  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      w_wmask[8*i +: 8] = {8{w_wbe[i]}};
    end
  end

  // Byte-masked memory write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (w_wbe[i]) begin
          r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data selection: old word, or merged new word on a write-first collision.
  always_comb begin
    w_rd_old  = r_mem[w_raddr];
    w_rd_next = w_rd_old;
    if (WRITE_FIRST && w_we && (w_waddr == w_raddr)) begin
      w_rd_next = (w_rd_old & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_next;
      end
    end
  end

  // Flag external writes swallowed by an active sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= wr_en && (r_state == S_CLEAR);
    end
  end

  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign wr_drop    = r_wr_drop;
  assign clear_busy = r_clear_busy;
  assign clear_done = r_clear_done;

endmodule
